// File: rtl/mmio_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mmio_uart_tx                                               |
// | Description : Memory-mapped serial transmitter. CPU stores to TXDATA     |
// |               queue bytes in a TX FIFO; the FIFO is drained onto tx as   |
// |               8N1 frames (8E1 when UART_TX_PARITY_EN is defined), LSB    |
// |               first. Loads from STATUS report FIFO/line state.           |
// | Ports       : clk        - system clock, rising edge                      |
// |               reset      - asynchronous active-low reset                  |
// |               mem_addr   - CPU data address (full 32-bit decode)          |
// |               mem_write  - store strobe                                   |
// |               mem_read   - load strobe (no side effects)                  |
// |               write_data - store data                                     |
// |               read_data  - load data, combinational                       |
// |               tx         - serial line, registered, idles high            |
// |               tx_busy    - high while a frame is on the line              |
// | Config      : UART_TX_PARITY_EN - adds an even-parity bit (8E1 frames)    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int              c_PW          = $clog2(FIFO_DEPTH);
  localparam int              c_CW          = $clog2(CLKS_PER_BIT);
  localparam logic [31:0]     c_STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [c_CW-1:0] c_BIT_LAST    = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_PW:0]   c_DEPTH       = (c_PW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW:0]   r_count;
  logic            r_overflow;

  // Transmit FSM
  state_t          r_state;
  logic [c_CW-1:0] r_bit_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
`ifdef UART_TX_PARITY_EN
  logic            r_parity;
`endif

  logic w_empty;
  logic w_full;
  logic w_bit_end;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_clr_ovf;
  logic w_unused;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_DEPTH);
  assign w_bit_end = (r_bit_cnt == c_BIT_LAST);

  // The FSM takes a byte either from idle or at the end of a stop bit, so
  // consecutive frames run back to back without an idle gap.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  // Fullness is judged after a same-edge pop, so push+pop on a full FIFO fits.
  assign w_push_req = mem_write && (mem_addr == BASE_ADDR);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_clr_ovf  = mem_write && (mem_addr == c_STATUS_ADDR) && write_data[3];

  // Upper store-data bits carry no meaning for this peripheral.
  assign w_unused = &{1'b0, write_data[31:8]};

  always_comb begin
    read_data = '0;
    if (mem_read && (mem_addr == c_STATUS_ADDR)) begin
      read_data = {28'b0, r_overflow, tx_busy, w_empty, w_full};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= write_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end else if (w_clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      r_bit_cnt <= w_bit_end ? '0 : r_bit_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
            r_parity <= ^r_mem[r_rd_ptr];
`endif
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            tx      <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx      <= r_parity;
              r_state <= ST_PARITY;
`else
              tx      <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              tx      <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            tx      <= 1'b1;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
              r_parity <= ^r_mem[r_rd_ptr];
`endif
              tx       <= 1'b0;
              r_state  <= ST_START;
            end else begin
              tx_busy  <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mmio_uart_tx                                            |
// | Description : Self-checking bench for mmio_uart_tx. Stores push expected |
// |               bytes into a scoreboard queue; a line monitor decodes each |
// |               frame from tx and compares it with the queue head.         |
// |               Directed checks cover timing, status and reset abort.      |
// | Config      : UART_TX_PARITY_EN - expects 8E1 frames                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mmio_uart_tx;

  localparam int          c_CPB   = 4;
  localparam logic [31:0] c_BASE  = 32'h4000_0010;
  localparam logic [31:0] c_STAT  = 32'h4000_0014;
`ifdef UART_TX_PARITY_EN
  localparam int          c_FRAME = 11 * c_CPB;
`else
  localparam int          c_FRAME = 10 * c_CPB;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        tx;
  logic        tx_busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q[$];
  bit mon_en = 1'b1;
  bit mon_busy = 1'b0;

  mmio_uart_tx #(
    .CLKS_PER_BIT(c_CPB),
    .FIFO_DEPTH  (8),
    .BASE_ADDR   (c_BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .write_data(write_data),
    .read_data (read_data),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; leaves the store active across the next posedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_addr   = a;
    write_data = d;
    mem_write  = 1'b1;
    @(negedge clk);
    mem_write  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    mem_read = 1'b1;
    #1;
    d = read_data;
    mem_read = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || tx_busy || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n, (n < budget) ? n : -1);
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k <= 4) return 1'b0;
    if (k <= 36) return b[(k - 5) / 4];
`ifdef UART_TX_PARITY_EN
    if (k <= 40) return ^b;
`endif
    return 1'b1;
  endfunction

  // Store one byte, then check tx and tx_busy on every cycle of its frame.
  task automatic timed_frame(input logic [7:0] b);
    sb_q.push_back(b);
    store(c_BASE, {24'h0, b});
    for (int k = 1; k <= c_FRAME + 1; k++) begin
      @(negedge clk);
      chk($sformatf("tx_%02h_k%0d", b, k), {31'b0, tx}, {31'b0, exp_tx(b, k)});
      chk($sformatf("busy_%02h_k%0d", b, k), {31'b0, tx_busy}, (k <= c_FRAME) ? 32'd1 : 32'd0);
    end
  endtask

  // Line monitor: decode frames at mid-bit and compare with the scoreboard.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (mon_en && reset && tx == 1'b0) begin
        mon_busy = 1'b1;
        repeat (2) @(negedge clk);
        chk("mon_start", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (c_CPB) @(negedge clk);
          got[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (c_CPB) @(negedge clk);
        chk("mon_parity", {31'b0, tx}, {31'b0, ^got});
`endif
        repeat (c_CPB) @(negedge clk);
        chk("mon_stop", {31'b0, tx}, 32'd1);
        if (sb_q.size() == 0) begin
          chk("mon_unexpected_frame", {24'h0, got}, 32'hFFFF_FFFF);
        end else begin
          exp = sb_q.pop_front();
          chk("mon_byte", {24'h0, got}, {24'h0, exp});
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stim
    logic [31:0] rd;
    int busy_cnt;
    int line_act;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, tx_busy}, 32'd0);
    load(c_STAT, rd);
    chk("rst_status", rd, 32'h2);
    load(c_BASE, rd);
    chk("rd_txdata", rd, 32'h0);
    load(32'h4000_0018, rd);
    chk("rd_other", rd, 32'h0);

    // 2: single 0x55 frame with exact timing
    timed_frame(8'h55);
    drain(200);

    // 3: two back-to-back frames, no idle gap
    sb_q.push_back(8'hA1);
    sb_q.push_back(8'h3C);
    store(c_BASE, 32'hA1);
    store(c_BASE, 32'h3C);
    busy_cnt = (tx_busy) ? 1 : 0;  // edge N+1 already passed
    for (int k = 2; k <= 2 * c_FRAME; k++) begin
      @(negedge clk);
      if (tx_busy) busy_cnt++;
    end
    chk("b2b_busy_cycles", busy_cnt, 2 * c_FRAME);
    @(negedge clk);
    chk("b2b_busy_drop", {31'b0, tx_busy}, 32'd0);
    drain(200);

    // 4: ten consecutive stores, 10th overflows
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb_q.push_back(8'(8'h10 + i));
      mem_addr   = c_BASE;
      write_data = 32'h10 + i;
      mem_write  = 1'b1;
      @(negedge clk);
    end
    mem_write = 1'b0;
    load(c_STAT, rd);
    chk("ovf_status", rd, 32'hD);
    store(c_STAT, 32'h8);
    load(c_STAT, rd);
    chk("ovf_cleared", rd, 32'h5);
    drain(1000);
    load(c_STAT, rd);
    chk("ovf_idle_status", rd, 32'h2);

    // 5: reset during DATA bit 3 of 0xFF, with another 0xFF queued
    mon_en = 1'b0;
    store(c_BASE, 32'hFF);
    store(c_BASE, 32'hFF);
    repeat (17) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_tx", {31'b0, tx}, 32'd1);
    chk("abort_busy", {31'b0, tx_busy}, 32'd0);
    load(c_STAT, rd);
    chk("abort_status", rd, 32'h2);
    @(negedge clk);
    reset = 1'b1;
    line_act = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!tx || tx_busy) line_act++;
    end
    chk("abort_no_frame", line_act, 0);
    mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
    // 6: parity frame of 0x07
    timed_frame(8'h07);
    drain(200);
`endif

    // recovery after reset: normal frame again
    sb_q.push_back(8'h96);
    store(c_BASE, 32'h96);
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
